// File: rtl/onchip_mem_stream_loader_pkg.sv
// Shared constants and FSM state type for the on-chip RAM stream loader.
// The RAM geometry constants are also used by the RAM slave wrapper, so both
// sides agree on address width, data width and depth.
package onchip_mem_stream_loader_pkg;

  localparam int unsigned MEM_ADDR_W = 14;     // RAM word-address width
  localparam int unsigned MEM_DATA_W = 32;     // RAM data width
  localparam int unsigned MEM_DEPTH  = 10240;  // RAM depth in words
  localparam int unsigned LD_CNT_W   = 15;     // job word-count width (holds MEM_DEPTH)

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } ld_state_t;

endpackage

// File: rtl/onchip_mem_stream_loader.sv
// Stream-to-RAM loader: writes a valid/ready word stream to consecutive RAM
// words starting at a programmed base address, for a programmed word count
// (or until in_last). Address wraps DEPTH-1 -> 0.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, base_addr,
//   word_count                 job request (sampled in IDLE only)
//   busy, done, cfg_err,
//   words_written              job status
//   in_data, in_valid,
//   in_last, in_ready          input word stream
//   mem_*                      RAM slave write interface (registered)
module onchip_mem_stream_loader
  import onchip_mem_stream_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned DEPTH  = MEM_DEPTH,
  parameter int unsigned CNT_W  = LD_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    word_count,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic [CNT_W-1:0]    words_written,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  output logic                mem_reset_req
);

  ld_state_t         r_state;
  ld_state_t         w_state_nxt;

  logic [ADDR_W-1:0] r_cur_addr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_words_written;
  logic              r_cfg_err;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_writedata;

  logic              w_cfg_bad;
  logic              w_accept;
  logic              w_final;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [CNT_W-1:0]  w_ww_inc;

  assign w_cfg_bad  = (word_count > CNT_W'(DEPTH)) || (base_addr >= ADDR_W'(DEPTH));
  assign w_accept   = (r_state == S_LOAD) && in_valid;
  assign w_ww_inc   = r_words_written + CNT_W'(1);
  // Beat being accepted now is the count-th word of the job.
  assign w_final    = (w_ww_inc == r_count);
  // Depth is not a power of two, so wrap by explicit compare.
  assign w_addr_nxt = (r_cur_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_cur_addr + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !w_cfg_bad) begin
          if (word_count == '0) w_state_nxt = S_DONE;
          else                  w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept && (in_last || w_final)) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        busy        = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_addr      <= '0;
      r_count         <= '0;
      r_words_written <= '0;
      r_cfg_err       <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
    end else begin
      // Write strobe is a one-cycle pulse per accepted beat.
      r_mem_write <= 1'b0;
      if ((r_state == S_IDLE) && start) begin
        if (w_cfg_bad) begin
          r_cfg_err <= 1'b1;
        end else begin
          r_cfg_err       <= 1'b0;
          r_words_written <= '0;
          r_cur_addr      <= base_addr;
          r_count         <= word_count;
        end
      end
      if (w_accept) begin
        r_mem_write     <= 1'b1;
        r_mem_address   <= r_cur_addr;
        r_mem_writedata <= in_data;
        r_cur_addr      <= w_addr_nxt;
        r_words_written <= w_ww_inc;
      end
    end
  end

  assign cfg_err        = r_cfg_err;
  assign words_written  = r_words_written;
  assign mem_write      = r_mem_write;
  assign mem_chipselect = r_mem_write;
  assign mem_address    = r_mem_address;
  assign mem_writedata  = r_mem_writedata;
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;
  assign mem_reset_req  = 1'b0;

endmodule
